// File: rtl/sd_fifo_pkg.sv
// Shared types and helpers for the SD data-path FIFOs (TX and RX instances).
package sd_fifo_pkg;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_status_t;

  // Pointer width for a power-of-two depth; never narrower than one bit.
  function automatic int fifo_aw(input int depth);
    int w;
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < depth) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/sd_fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read, no reset on the array.
module sd_fifo_ram #(
  parameter int DW    = 32,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sd_fifo_sc.sv
// Single-clock data FIFO with FWFT or registered read, thresholds, level/free counts,
// synchronous flush and sticky overflow/underflow flags.
module sd_fifo_sc
  import sd_fifo_pkg::*;
#(
  parameter int DW        = 32,
  parameter int DEPTH     = 16,
  parameter int AW        = fifo_aw(DEPTH),
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          clr_err,
  input  logic [DW-1:0] d,
  input  logic          wr,
  input  logic          rd,
  output logic [DW-1:0] q,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [AW:0]   level,
  output logic [AW:0]   free,
  output logic          ovf,
  output logic          udf
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_L    = (AW+1)'(AF_THRESH);
  localparam logic [AW:0] AE_L    = (AW+1)'(AE_THRESH);
  localparam logic [AW:0] ONE_L   = (AW+1)'(1);

  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   level_r, free_r, level_nxt;
  fifo_status_t  sts, sts_nxt;
  logic          acc_wr, acc_rd, ovf_set, udf_set;
  logic          ovf_r, udf_r;
  logic [DW-1:0] rdata;

  // Acceptance uses the flags registered at the start of the cycle; flush masks everything.
  assign acc_wr  = wr && !sts.full  && !flush;
  assign acc_rd  = rd && !sts.empty && !flush;
  assign ovf_set = wr &&  sts.full  && !flush;
  assign udf_set = rd &&  sts.empty && !flush;

  always_comb begin
    level_nxt = level_r;
    if (flush)                level_nxt = '0;
    else if (acc_wr && !acc_rd) level_nxt = level_r + ONE_L;
    else if (!acc_wr && acc_rd) level_nxt = level_r - ONE_L;

    sts_nxt.full         = (level_nxt == DEPTH_L);
    sts_nxt.empty        = (level_nxt == '0);
    sts_nxt.almost_full  = (level_nxt >= AF_L);
    sts_nxt.almost_empty = (level_nxt <= AE_L);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr    <= '0;
      rptr    <= '0;
      level_r <= '0;
      free_r  <= DEPTH_L;
      sts     <= '{full: 1'b0, empty: 1'b1, almost_full: 1'b0, almost_empty: 1'b1};
      ovf_r   <= 1'b0;
      udf_r   <= 1'b0;
    end else begin
      if (flush) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (acc_wr) wptr <= wptr + 1'b1;
        if (acc_rd) rptr <= rptr + 1'b1;
      end
      level_r <= level_nxt;
      free_r  <= DEPTH_L - level_nxt;
      sts     <= sts_nxt;
      // A fresh error in the same cycle as clr_err keeps the flag set.
      ovf_r   <= ovf_set || (ovf_r && !clr_err);
      udf_r   <= udf_set || (udf_r && !clr_err);
    end
  end

  sd_fifo_ram #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (acc_wr),
    .waddr (wptr),
    .wdata (d),
    .raddr (rptr),
    .rdata (rdata)
  );

  generate
    if (FWFT != 0) begin : g_fwft
      assign q = rdata;
    end else begin : g_reg
      logic [DW-1:0] q_r;
      always_ff @(posedge clk) begin
        if (rst)         q_r <= '0;
        else if (acc_rd) q_r <= rdata;
      end
      assign q = q_r;
    end
  endgenerate

  assign full         = sts.full;
  assign empty        = sts.empty;
  assign almost_full  = sts.almost_full;
  assign almost_empty = sts.almost_empty;
  assign level        = level_r;
  assign free         = free_r;
  assign ovf          = ovf_r;
  assign udf          = udf_r;

endmodule

// File: tb/tb_sd_fifo_sc.sv
// Directed bench for sd_fifo_sc: one FWFT instance driven from a vector table, one registered-read instance.
module tb_sd_fifo_sc;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // FWFT instance
  logic        flush, clr_err, wr, rd;
  logic [31:0] d, q;
  logic        full, empty, af, ae, ovf, udf;
  logic [4:0]  level, free;

  // Registered-read instance
  logic        flush_b, clr_err_b, wr_b, rd_b;
  logic [31:0] d_b, q_b;
  logic        full_b, empty_b, af_b, ae_b, ovf_b, udf_b;
  logic [4:0]  level_b, free_b;

  sd_fifo_sc #(.DW(32), .DEPTH(16), .FWFT(1)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .clr_err(clr_err), .d(d), .wr(wr), .rd(rd),
    .q(q), .full(full), .empty(empty), .almost_full(af), .almost_empty(ae),
    .level(level), .free(free), .ovf(ovf), .udf(udf)
  );

  sd_fifo_sc #(.DW(32), .DEPTH(16), .FWFT(0)) dut_b (
    .clk(clk), .rst(rst), .flush(flush_b), .clr_err(clr_err_b), .d(d_b), .wr(wr_b), .rd(rd_b),
    .q(q_b), .full(full_b), .empty(empty_b), .almost_full(af_b), .almost_empty(ae_b),
    .level(level_b), .free(free_b), .ovf(ovf_b), .udf(udf_b)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic        fl, ce, w, r;
    logic [31:0] dd;
    logic [4:0]  lvl;
    logic        full, empty, af, ae, ovf, udf;
    logic        cq;
    logic [31:0] q;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string name, input logic fl, ce, w, r, input logic [31:0] dd,
                              input int lvl, input logic eo, eu, cq, input logic [31:0] eq);
    vec_t v;
    v.name = name; v.fl = fl; v.ce = ce; v.w = w; v.r = r; v.dd = dd;
    v.lvl = 5'(lvl);
    v.full = (lvl == 16); v.empty = (lvl == 0); v.af = (lvl >= 14); v.ae = (lvl <= 2);
    v.ovf = eo; v.udf = eu; v.cq = cq; v.q = eq;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic fl, ce, w, r, input logic [31:0] dd);
    flush = fl; clr_err = ce; wr = w; rd = r; d = dd;
  endtask

  task automatic chk_a(input string tag, input int lvl, input logic eo, eu);
    chk({tag, ".level"}, 32'(level), 32'(lvl));
    chk({tag, ".free"},  32'(free),  32'(16 - lvl));
    chk({tag, ".full"},  32'(full),  32'(lvl == 16));
    chk({tag, ".empty"}, 32'(empty), 32'(lvl == 0));
    chk({tag, ".ovf"},   32'(ovf),   32'(eo));
    chk({tag, ".udf"},   32'(udf),   32'(eu));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    // Vector table: fill, overflow, drain, underflow/clear corners.
    for (int i = 0; i < 16; i++)
      vecs.push_back(mk("fill", 0, 0, 1, 0, 32'h1000 + i, i + 1, 0, 0, 1, 32'h1000));
    vecs.push_back(mk("wr_full", 0, 0, 1, 0, 32'hDEAD, 16, 1, 0, 1, 32'h1000));
    for (int k = 0; k < 16; k++)
      vecs.push_back(mk("drain", 0, 0, 0, 1, 0, 15 - k, 1, 0, k < 15, 32'h1000 + k + 1));
    vecs.push_back(mk("clr_ovf",     0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("rd_empty",    0, 0, 0, 1, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk("clr_udf",     0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("clr_vs_udf",  0, 1, 0, 1, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk("empty_wr_rd", 0, 0, 1, 1, 32'h3333, 1, 0, 1, 1, 32'h3333));
    vecs.push_back(mk("rd_clr",      0, 1, 0, 1, 0, 0, 0, 0, 0, 0));

    rst = 1'b1;
    drive_a(0, 0, 0, 0, 0);
    flush_b = 0; clr_err_b = 0; wr_b = 0; rd_b = 0; d_b = 0;
    tick();
    tick();
    chk_a("reset", 0, 0, 0);
    chk("reset.almost_empty", 32'(ae), 32'd1);
    chk("reset.almost_full",  32'(af), 32'd0);
    chk("reset_b.q",     q_b, 32'h0);
    chk("reset_b.empty", 32'(empty_b), 32'd1);
    chk("reset_b.free",  32'(free_b),  32'd16);
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive_a(vecs[i].fl, vecs[i].ce, vecs[i].w, vecs[i].r, vecs[i].dd);
      tick();
      chk({vecs[i].name, ".level"}, 32'(level), 32'(vecs[i].lvl));
      chk({vecs[i].name, ".free"},  32'(free),  32'(5'd16 - vecs[i].lvl));
      chk({vecs[i].name, ".full"},  32'(full),  32'(vecs[i].full));
      chk({vecs[i].name, ".empty"}, 32'(empty), 32'(vecs[i].empty));
      chk({vecs[i].name, ".af"},    32'(af),    32'(vecs[i].af));
      chk({vecs[i].name, ".ae"},    32'(ae),    32'(vecs[i].ae));
      chk({vecs[i].name, ".ovf"},   32'(ovf),   32'(vecs[i].ovf));
      chk({vecs[i].name, ".udf"},   32'(udf),   32'(vecs[i].udf));
      if (vecs[i].cq) chk({vecs[i].name, ".q"}, q, vecs[i].q);
    end

    // Steady level 5 with simultaneous wr+rd across pointer wrap.
    for (int n = 0; n < 5; n++) begin
      drive_a(0, 0, 1, 0, 32'h2000 + n);
      tick();
    end
    chk_a("lvl5", 5, 0, 0);
    for (int j = 0; j < 20; j++) begin
      drive_a(0, 0, 1, 1, 32'h2000 + 5 + j);
      tick();
      chk("steady.level", 32'(level), 32'd5);
      chk("steady.q", q, 32'h2000 + j + 1);
    end
    for (int m = 0; m < 5; m++) begin
      chk("steady_drain.q", q, 32'h2000 + 20 + m);
      drive_a(0, 0, 0, 1, 0);
      tick();
    end
    chk_a("steady_end", 0, 0, 0);

    // Full with wr+rd: read wins, write rejected, ovf set.
    for (int n = 0; n < 16; n++) begin
      drive_a(0, 0, 1, 0, 32'h4000 + n);
      tick();
    end
    chk_a("full16", 16, 0, 0);
    drive_a(0, 0, 1, 1, 32'h5555);
    tick();
    chk_a("full_wr_rd", 15, 1, 0);
    chk("full_wr_rd.q", q, 32'h4001);

    // Down to level 9, then flush with wr asserted.
    for (int n = 0; n < 6; n++) begin
      drive_a(0, 0, 0, 1, 0);
      tick();
    end
    chk_a("lvl9", 9, 1, 0);
    drive_a(1, 0, 1, 0, 32'hBEEF);
    tick();
    chk_a("flush", 0, 1, 0);
    chk("flush.almost_empty", 32'(ae), 32'd1);
    drive_a(0, 0, 1, 0, 32'hCAFE);
    tick();
    chk_a("after_flush_wr", 1, 1, 0);
    chk("after_flush_wr.q", q, 32'hCAFE);
    drive_a(0, 0, 0, 1, 0);
    tick();
    drive_a(1, 0, 0, 1, 0);
    tick();
    chk_a("flush_rd_empty", 0, 1, 0);
    drive_a(0, 0, 0, 0, 0);

    // Registered-read instance.
    wr_b = 1; d_b = 32'hA5A5;
    tick();
    d_b = 32'h5A5A;
    tick();
    wr_b = 0;
    chk("regrd.q_before_rd", q_b, 32'h0);
    chk("regrd.level", 32'(level_b), 32'd2);
    rd_b = 1;
    tick();
    rd_b = 0;
    chk("regrd.q_first", q_b, 32'hA5A5);
    tick();
    chk("regrd.q_hold", q_b, 32'hA5A5);
    wr_b = 1; d_b = 32'h1111;
    tick();
    wr_b = 0;
    chk("regrd.q_hold_wr", q_b, 32'hA5A5);
    rd_b = 1;
    tick();
    rd_b = 0;
    chk("regrd.q_second", q_b, 32'h5A5A);
    flush_b = 1;
    tick();
    flush_b = 0;
    chk("regrd.q_flush_hold", q_b, 32'h5A5A);
    chk("regrd.flush_level", 32'(level_b), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
